// File: rtl/vu_pkg.sv
// Shared definitions for the VU level meter: peak FSM encodings, byte width, LED step.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package vu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      FALL = 2'd2
   } pk_state_t;

   localparam int BYTE_W = 8;

   // Magnitude span covered by one LED of the bar.
   function automatic int led_step(input int led_no);
      return 256 / led_no;
   endfunction

endpackage

// File: rtl/vu_tick_gen.sv
// Free-running divider: one-cycle tick every DIV clocks.
// Latency: first tick is sampled DIV edges after reset release.
// Backpressure: none; runs unconditionally.
// Ports: clk, rst (async active-high), tick (high while the counter sits at DIV-1).
module vu_tick_gen #(
   parameter int DIV = 1000000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt;

   // tick is decoded from the counter state, so the edge that sees it high is
   // also the edge on which the counter wraps back to zero.
   assign tick = (cnt == CW'(DIV - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/vu_level_meter.sv
// VU meter: instant-attack / linear-decay level, held peak, LED bar + peak dot, error count.
// Latency: level/peak update on the sampling edge; LED outputs one edge later; err_cnt on the sampling edge.
// Backpressure: none; a strobe is accepted every cycle, nothing is ever stalled.
// Ports: clk, rst (async active-high); data_in/data_valid/format_err from the UART receiver;
//        led_bar (thermometer), led_peak (one-hot peak dot), err_cnt (saturating rejected-byte count).
module vu_level_meter
   import vu_pkg::*;
#(
   parameter int LED_NO     = 8,
   parameter int DECAY_DIV  = 1000000,
   parameter int DECAY_STEP = 8,
   parameter int HOLD_TICKS = 50
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [BYTE_W-1:0] data_in,
   input  logic              data_valid,
   input  logic              format_err,
   output logic [LED_NO-1:0] led_bar,
   output logic [LED_NO-1:0] led_peak,
   output logic [BYTE_W-1:0] err_cnt
);

   localparam int              STEP    = led_step(LED_NO);
   localparam logic [BYTE_W-1:0] STEP_B  = BYTE_W'(STEP);
   localparam logic [BYTE_W-1:0] DSTEP_B = BYTE_W'(DECAY_STEP);
   localparam logic [BYTE_W-1:0] HOLD_B  = BYTE_W'(HOLD_TICKS);
   localparam logic [BYTE_W-1:0] ERR_MAX = 8'd255;

   function automatic logic [BYTE_W-1:0] sat_sub(input logic [BYTE_W-1:0] a,
                                                 input logic [BYTE_W-1:0] b);
      return (a > b) ? (a - b) : '0;
   endfunction

   logic              tick;
   logic              accept;
   logic              reject;
   logic [BYTE_W-1:0] level;
   logic [BYTE_W-1:0] peak;
   logic [BYTE_W-1:0] hold_cnt;
   pk_state_t         pk_state;

   logic [BYTE_W-1:0] lvl_dec;
   logic [BYTE_W-1:0] level_nx;
   logic [BYTE_W-1:0] pk_dec;
   logic [BYTE_W-1:0] peak_eff;
   logic              retrig;
   logic              lift;
   logic [BYTE_W-1:0] peak_idx;
   logic [LED_NO-1:0] bar_nx;
   logic [LED_NO-1:0] dot_nx;

   vu_tick_gen #(
      .DIV (DECAY_DIV)
   ) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   assign accept = data_valid & ~format_err;
   assign reject = data_valid &  format_err;

   // Decay is applied before the max, so a sample arriving on a tick competes
   // against the already-decayed level.
   assign lvl_dec  = tick ? sat_sub(level, DSTEP_B) : level;
   assign level_nx = (accept && (data_in > lvl_dec)) ? data_in : lvl_dec;

   // A falling peak is compared against its post-decay value on tick cycles.
   assign pk_dec   = sat_sub(peak, DSTEP_B);
   assign peak_eff = (tick && (pk_state == FALL)) ? pk_dec : peak;
   assign retrig   = accept && (data_in != '0) && (data_in >= peak_eff);
   assign lift     = (level_nx > peak_eff);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level <= '0;
      end else begin
         level <= level_nx;
      end
   end

   // Peak FSM. On a re-trigger level_nx equals data_in (the decayed level can
   // never exceed peak_eff), so loading level_nx covers both the re-trigger
   // and the keep-peak-above-level case with one assignment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pk_state <= IDLE;
         peak     <= '0;
         hold_cnt <= '0;
      end else if (retrig || lift) begin
         pk_state <= HOLD;
         peak     <= level_nx;
         hold_cnt <= HOLD_B;
      end else begin
         case (pk_state)
            HOLD: begin
               if (tick) begin
                  if (hold_cnt <= 8'd1) begin
                     hold_cnt <= '0;
                     pk_state <= FALL;
                  end else begin
                     hold_cnt <= hold_cnt - 8'd1;
                  end
               end
            end
            FALL: begin
               if (tick) begin
                  peak <= pk_dec;
                  if (pk_dec == '0) begin
                     pk_state <= IDLE;
                  end
               end
            end
            default: begin
               pk_state <= IDLE;
            end
         endcase
      end
   end

   assign peak_idx = (peak - 8'd1) / STEP_B;

   always_comb begin
      bar_nx = '0;
      dot_nx = '0;
      for (int i = 0; i < LED_NO; i++) begin
         bar_nx[i] = (level > BYTE_W'(i * STEP));
         dot_nx[i] = (peak != '0) && (peak_idx == BYTE_W'(i));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         led_bar  <= '0;
         led_peak <= '0;
      end else begin
         led_bar  <= bar_nx;
         led_peak <= dot_nx;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt <= '0;
      end else if (reject && (err_cnt != ERR_MAX)) begin
         err_cnt <= err_cnt + 8'd1;
      end
   end

endmodule
